// File: rtl/add64_sequencer_if.sv
// -----------------------------------------------------------------------------
// add64_sequencer_if
// Handshake and data bundle for add64_sequencer.
//   in_valid / in_ready   : operand-set handshake (a, b, sub, c_in)
//   out_valid / out_ready : result handshake (sum, c_out, ovf)
//   busy                  : sequencer is not idle
// modport master : the side that offers operands and consumes results
// modport slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface add64_sequencer_if #(
    parameter int NUM_WORDS = 4
);
    localparam int W = 16 * NUM_WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, sub, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sub, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, busy
    );
endinterface

// File: rtl/add64_sequencer.sv
// -----------------------------------------------------------------------------
// add64_sequencer
// W-bit (W = 16*NUM_WORDS) add/subtract built from a single 16-bit
// carry-lookahead slice that is reused once per 16-bit word, least
// significant word first.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-low reset
//   bus  : add64_sequencer_if.slave (operand/result handshakes, busy)
// A result appears NUM_WORDS cycles after the accepting edge and is held
// until the consumer raises out_ready.
// -----------------------------------------------------------------------------
module add64_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    add64_sequencer_if.slave   bus
);
    localparam int W     = 16 * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;     // b, or ~b for subtraction
    logic [W-1:0]     sum_reg;
    logic             c_out_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [15:0]      slice_a;
    logic [15:0]      slice_b;
    logic [15:0]      slice_sum;
    logic             slice_co;

    assign slice_a = a_reg[16*idx +: 16];
    assign slice_b = b_reg[16*idx +: 16];

    CLA_16bit_LCU u_slice (
        .x  (slice_a),
        .y  (slice_b),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co)
    );

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.sum       = sum_reg;
    assign bus.c_out     = c_out_reg;
    assign bus.ovf       = ovf_reg;

    // The sub flag itself is not kept: its whole effect is captured by the
    // inverted operand and the forced carry-in, so a - b = a + ~b + 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            c_out_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.sub ? ~bus.b : bus.b;
                        carry        <= bus.sub ? 1'b1 : bus.c_in;
                        idx          <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    sum_reg[16*idx +: 16] <= slice_sum;
                    carry                 <= slice_co;
                    idx                   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        c_out_reg     <= slice_co;
                        // Same-sign operands whose result sign differs.
                        ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) &&
                                         (slice_sum[15] != a_reg[W-1]);
                        out_valid_reg <= 1'b1;
                        idx           <= '0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// -----------------------------------------------------------------------------
// CLA_16bit_LCU
// 16-bit adder: four 4-bit groups, each reporting group generate/propagate
// to a lookahead carry unit that produces every group carry-in and the
// carry-out directly from ci.
// Ports: x, y operands; ci carry-in; s sum; co carry-out of bit 15.
// -----------------------------------------------------------------------------
module CLA_16bit_LCU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    logic        bc;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        s  = '0;
        bc = 1'b0;
        co = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        // Lookahead carry unit
        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & ci);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & ci);
        co    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
        // Bit carries inside each group start from the group carry-in
        for (int k = 0; k < 4; k++) begin
            bc = gc[k];
            for (int i = 0; i < 4; i++) begin
                s[4*k+i] = p[4*k+i] ^ bc;
                bc       = g[4*k+i] | (p[4*k+i] & bc);
            end
        end
    end
endmodule

// File: tb/tb_add64_sequencer.sv
// -----------------------------------------------------------------------------
// tb_add64_sequencer
// Self-checking bench for add64_sequencer with NUM_WORDS = 4: a table of
// directed vectors, randomized operations against an arithmetic reference,
// a result-hold sequence and a mid-operation reset.
// -----------------------------------------------------------------------------
module tb_add64_sequencer;
    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    add64_sequencer_if #(.NUM_WORDS(4)) bus ();

    add64_sequencer #(.NUM_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        logic [63:0] esum;
        logic        eco;
        logic        eovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular and signed-integer arithmetic on the full width.
    task automatic model(input logic [63:0] av, input logic [63:0] bv, input logic s,
                         input logic ci, output logic [63:0] rs, output logic rco,
                         output logic rovf);
        logic [64:0]        u;
        logic signed [65:0] t;
        if (s) begin
            rs  = av - bv;
            rco = (av >= bv);
            t   = $signed({{2{av[63]}}, av}) - $signed({{2{bv[63]}}, bv});
        end else begin
            u   = {1'b0, av} + {1'b0, bv} + {64'd0, ci};
            rs  = u[63:0];
            rco = u[64];
            t   = $signed({{2{av[63]}}, av}) + $signed({{2{bv[63]}}, bv})
                + $signed({65'd0, ci});
        end
        rovf = (t > SMAX) || (t < SMIN);
    endtask

    // Offers one operand set and waits for out_valid; lat = edges after accept.
    task automatic do_op(input logic [63:0] av, input logic [63:0] bv, input logic s,
                         input logic ci, output int lat);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("in_ready before accept", 64'(bus.in_ready), 64'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.sub      = s;
        bus.c_in     = ci;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.sub      = ~s;
        bus.c_in     = ~ci;
        check("busy/in_ready/out_valid after accept",
              64'({bus.busy, bus.in_ready, bus.out_valid}), 64'b100);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("in_ready/busy/out_valid after release",
              64'({bus.in_ready, bus.busy, bus.out_valid}), 64'b100);
    endtask

    task automatic run_checked(input string tag, input logic [63:0] av, input logic [63:0] bv,
                               input logic s, input logic ci, input logic [63:0] esum,
                               input logic eco, input logic eovf);
        int lat;
        do_op(av, bv, s, ci, lat);
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, bus.sum, esum);
        check({tag, " c_out,ovf"}, 64'({bus.c_out, bus.ovf}), 64'({eco, eovf}));
        release_result();
    endtask

    initial begin
        logic [63:0] ra, rb, rs, hs;
        logic        rsub, rci, rco, rovf, hco, hovf;
        int          lat;
        logic        saw_valid;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[8] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.c_in      = 1'b0;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("reset out_valid/busy", 64'({bus.out_valid, bus.busy}), 64'b00);
        check("reset sum", bus.sum, 64'h0);
        check("reset c_out/ovf", 64'({bus.c_out, bus.ovf}), 64'b00);
        rst = 1'b1;
        tick();
        check("in_ready after reset", 64'(bus.in_ready), 64'd1);

        // Directed table
        foreach (vecs[i]) begin
            run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                        vecs[i].cin, vecs[i].esum, vecs[i].eco, vecs[i].eovf);
        end

        // Randomized against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            if (i % 5 == 0) ra = 64'h7FFF_FFFF_FFFF_FFFF;
            if (i % 7 == 0) rb = 64'hFFFF_FFFF_FFFF_FFFF;
            rsub = 1'($urandom_range(0, 1));
            rci  = 1'($urandom_range(0, 1));
            model(ra, rb, rsub, rci, rs, rco, rovf);
            run_checked($sformatf("rand%0d", i), ra, rb, rsub, rci, rs, rco, rovf);
        end

        // Result held while out_ready is low, even with new operands offered
        model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, hs, hco, hovf);
        do_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, lat);
        check("hold latency", 64'(lat), 64'd4);
        for (int c = 0; c < 10; c++) begin
            bus.in_valid  = 1'b1;
            bus.a         = {$urandom, $urandom};
            bus.b         = {$urandom, $urandom};
            bus.sub       = 1'($urandom_range(0, 1));
            bus.out_ready = 1'b0;
            tick();
            check($sformatf("hold%0d out_valid/in_ready", c),
                  64'({bus.out_valid, bus.in_ready}), 64'b10);
            check($sformatf("hold%0d sum", c), bus.sum, hs);
            check($sformatf("hold%0d c_out/ovf", c), 64'({bus.c_out, bus.ovf}), 64'({hco, hovf}));
        end
        release_result();

        // Reset while idx = 2 in CALC aborts the operation
        bus.a        = 64'h1111_2222_3333_4444;
        bus.b        = 64'h1;
        bus.sub      = 1'b0;
        bus.c_in     = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort out_valid/busy/in_ready",
              64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
        check("abort sum", bus.sum, 64'h0);
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
        end
        check("abort no out_valid", 64'(saw_valid), 64'd0);
        run_checked("after abort", 64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
